// File: rtl/fig_17_instruction_prefetch.sv
// Instruction prefetch for R15: fetches opcode bytes at pc into a small FIFO
// for the decoder, pulses pcen per accepted byte, flushes on pc_load.
module fig_17_instruction_prefetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic              hold,
  output logic              pcen,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_data,
  output logic [ADDR_W-1:0] op_addr,
  input  logic              op_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t state;

  logic [CW-1:0]     count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic push;
  logic pop;
  logic issue;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Only a clean REQ ack advances R15, so pc and mem_addr stay in step.
  assign pcen = ~reset & (state == REQ) & mem_ack
              & ~pc_load & ~hold;

  assign push     = pcen;
  assign op_valid = (count != '0);
  assign pop      = op_valid & op_ready;
  assign op_data  = data_q[head];
  assign op_addr  = addr_q[head];

  assign issue = (state == IDLE) & (count < CW'(DEPTH))
               & ~hold & ~pc_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (pc_load) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (pc_load) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= mem_addr;
        data_q[tail] <= mem_rdata;
        tail         <= bump(tail);
      end
      if (pop) begin
        head <= bump(head);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fig_17_instruction_prefetch.sv
// Bench for fig_17_instruction_prefetch: directed vector table plus
// randomized traffic against a queue-based fetch/decoder model.
module tb_fig_17_instruction_prefetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = '0;
  logic        pc_load = 1'b0;
  logic        hold = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        op_ready = 1'b0;
  logic        pcen;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        op_valid;
  logic [7:0]  op_data;
  logic [15:0] op_addr;

  fig_17_instruction_prefetch #(
    .ADDR_W(16),
    .DATA_W(8),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .pc_load  (pc_load),
    .hold     (hold),
    .pcen     (pcen),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .op_valid (op_valid),
    .op_data  (op_data),
    .op_addr  (op_addr),
    .op_ready (op_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int wait_cnt = 0;
  int lat = 0;
  logic [15:0] pc_nxt = '0;

  logic        s_pcen, s_req, s_ack, s_valid;
  logic [15:0] s_addr, s_opaddr;
  logic [7:0]  s_opdata;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, let combinational outputs settle, sample.
  task automatic drive(input logic rst, input logic ld,
                       input logic [15:0] ldv, input logic hd,
                       input logic rdy, input logic fack,
                       input logic rnd);
    @(negedge clk);
    pc       = pc_nxt;
    reset    = rst;
    pc_load  = ld;
    hold     = hd;
    op_ready = rdy;
    if (rnd && mem_req && wait_cnt == 0) lat = $urandom_range(0, 3);
    mem_ack   = fack | (mem_req && wait_cnt >= lat);
    mem_rdata = mem_ack ? rom(mem_addr) : 8'h00;
    #1;
    s_pcen   = pcen;
    s_req    = mem_req;
    s_ack    = mem_ack;
    s_valid  = op_valid;
    s_addr   = mem_addr;
    s_opaddr = op_addr;
    s_opdata = op_data;
    if (s_req && !s_ack && !rst) wait_cnt++;
    else wait_cnt = 0;
    pc_nxt = ld ? ldv : (s_pcen ? pc + 16'd1 : pc);
  endtask

  typedef struct {
    logic        rst;
    logic        ld;
    logic [15:0] ldv;
    logic        hd;
    logic        rdy;
    int          lat;
    logic        fack;
    logic        chk;
    logic        chkop;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_pcen;
    logic        e_valid;
    logic [15:0] e_op;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    input logic rst, input logic ld, input logic [15:0] ldv,
    input logic hd, input logic rdy, input int lt, input logic fack,
    input logic c, input logic cop, input logic rq,
    input logic [15:0] ad, input logic pe, input logic vl,
    input logic [15:0] op);
    vec_t r;
    r.rst = rst; r.ld = ld; r.ldv = ldv; r.hd = hd; r.rdy = rdy;
    r.lat = lt; r.fack = fack; r.chk = c; r.chkop = cop;
    r.e_req = rq; r.e_addr = ad; r.e_pcen = pe;
    r.e_valid = vl; r.e_op = op;
    return r;
  endfunction

  // scoreboard state for the random phase
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t q[$];

  initial begin
    logic p_req, p_ack, p_hd, p_ld, p_rst, clean, e_pcen, e_req;
    logic ld, hd, rdy;
    logic [15:0] ldv, iss_addr;
    int p_qs, npush;
    ent_t e;

    // zero-wait streaming
    v.push_back(mk(1,1,16'h0100,0,1,0,0, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'h0100,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'h0100));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'h0101,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'h0101));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'h0102,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'h0102));
    // decoder stalled: fill to DEPTH, then flush
    v.push_back(mk(1,1,16'h0300,0,0,0,0, 0,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 1,16'h0300,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 0,16'h0000,0,1,16'h0300));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 1,16'h0301,1,1,16'h0300));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 0,16'h0000,0,1,16'h0300));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 0,16'h0000,0,1,16'h0300));
    v.push_back(mk(0,1,16'h0500,0,0,0,0, 1,0, 0,16'h0000,0,1,16'h0300));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 1,16'h0500,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,0,0,0, 1,0, 0,16'h0000,0,1,16'h0500));
    // slow ack, pc_load while outstanding
    v.push_back(mk(1,1,16'h1000,0,1,3,0, 0,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,3,0, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,3,0, 1,0, 1,16'h1000,0,0,16'h0000));
    v.push_back(mk(0,1,16'h2000,0,1,3,0, 1,0, 1,16'h1000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,3,0, 1,0, 1,16'h1000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,3,0, 1,0, 1,16'h1000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'h2000,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'h2000));
    // pc_load and ack together
    v.push_back(mk(1,1,16'h3000,0,1,0,0, 0,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,1,16'h4000,0,1,0,0, 1,0, 1,16'h3000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'h4000,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'h4000));
    // hold across an outstanding ack, then refetch
    v.push_back(mk(1,1,16'h5000,0,1,2,0, 0,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,2,0, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,2,0, 1,0, 1,16'h5000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,1,1,2,0, 1,0, 1,16'h5000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,1,1,2,0, 1,0, 1,16'h5000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,1,1,0,0, 1,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'h5000,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'h5000));
    // wrap, then reset mid-request and a stray ack
    v.push_back(mk(1,1,16'hFFFF,0,1,0,0, 0,0, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'hFFFF,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'hFFFF));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 1,16'h0000,1,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,0,0, 1,0, 0,16'h0000,0,1,16'h0000));
    v.push_back(mk(0,0,16'h0000,0,1,3,0, 1,0, 1,16'h0001,0,0,16'h0000));
    v.push_back(mk(1,0,16'h0000,0,1,3,0, 1,0, 1,16'h0001,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,1,1,3,1, 1,1, 0,16'h0000,0,0,16'h0000));
    v.push_back(mk(0,0,16'h0000,1,1,3,0, 1,1, 0,16'h0000,0,0,16'h0000));

    for (int i = 0; i < v.size(); i++) begin
      lat = v[i].lat;
      drive(v[i].rst, v[i].ld, v[i].ldv, v[i].hd, v[i].rdy,
            v[i].fack, 1'b0);
      if (v[i].chk) begin
        chk($sformatf("row%0d_req", i), 32'(s_req), 32'(v[i].e_req));
        chk($sformatf("row%0d_pcen", i), 32'(s_pcen), 32'(v[i].e_pcen));
        chk($sformatf("row%0d_valid", i), 32'(s_valid),
            32'(v[i].e_valid));
        if (v[i].e_req || v[i].chkop)
          chk($sformatf("row%0d_addr", i), 32'(s_addr),
              32'(v[i].chkop ? 16'h0000 : v[i].e_addr));
        if (v[i].e_valid || v[i].chkop) begin
          chk($sformatf("row%0d_opaddr", i), 32'(s_opaddr),
              32'(v[i].e_op));
          chk($sformatf("row%0d_opdata", i), 32'(s_opdata),
              32'(v[i].e_valid ? rom(v[i].e_op) : 8'h00));
        end
      end
    end

    // randomized traffic against the fetch/decoder model
    drive(1'b1, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    p_req = 0; p_ack = 0; p_hd = 0; p_ld = 0; p_rst = 1;
    p_qs = 0; clean = 0; iss_addr = '0; npush = 0;
    q.delete();
    for (int n = 0; n < 4000; n++) begin
      ld  = ($urandom_range(0, 15) == 0);
      ldv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ldv = 16'hFFFE;
      hd  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      drive(1'b0, ld, ldv, hd, rdy, 1'b0, 1'b1);

      if (p_rst) e_req = 1'b0;
      else if (p_req) e_req = !p_ack;
      else e_req = !p_hd && !p_ld && (p_qs < DEPTH);
      chk("rnd_req", 32'(s_req), 32'(e_req));
      if (s_req && !p_req) begin
        chk("rnd_issue_addr", 32'(s_addr), 32'(pc));
        iss_addr = pc;
        clean = 1'b1;
      end
      if (s_req) chk("rnd_addr_stable", 32'(s_addr), 32'(iss_addr));

      e_pcen = s_req && s_ack && clean && !ld && !hd;
      chk("rnd_pcen", 32'(s_pcen), 32'(e_pcen));
      if (ld && s_req && !s_ack) clean = 1'b0;

      chk("rnd_valid", 32'(s_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd_opaddr", 32'(s_opaddr), 32'(q[0].a));
        chk("rnd_opdata", 32'(s_opdata), 32'(q[0].d));
      end

      p_qs = q.size();
      if (ld) begin
        q.delete();
      end else begin
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (e_pcen) begin
          e.a = pc;
          e.d = rom(pc);
          q.push_back(e);
          npush++;
        end
      end
      p_req = s_req; p_ack = s_ack; p_hd = hd; p_ld = ld; p_rst = 0;
    end
    chk("rnd_progress", 32'(npush > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
